sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_BITS, default 10, SHALL set the number of implemented word addresses to 2^ADDR_BITS.
REQ-002 Parameter READ_LAT, default 2, legal 1..7, SHALL set the cycle count from read acceptance to data valid.
REQ-003 Port Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port Reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port CE  input  1  SHALL be the active-low chip enable.
REQ-006 Port OE  input  1  SHALL be the active-low output enable (read strobe).
REQ-007 Port WE  input  1  SHALL be the active-low write enable.
REQ-008 Port UB  input  1  SHALL be the active-low upper-byte lane enable, bits 15:8.
REQ-009 Port LB  input  1  SHALL be the active-low lower-byte lane enable, bits 7:0.
REQ-010 Port A  input  20  SHALL be the word address.
REQ-011 Port Data_in  input  16  SHALL be the write data from the initiator.
REQ-012 Port Data_out  output  16  SHALL be the registered read data to the initiator.
REQ-013 Port Ready  output  1  SHALL pulse high for one cycle when an access completes.
REQ-014 Port Err  output  1  SHALL pulse high with Ready when the access targeted an unimplemented address.

Function
REQ-015 FSM states: IDLE, RD_WAIT, WR_COMMIT, DONE.
REQ-016 In IDLE, CE=0 and WE=0 SHALL accept a write (WE wins when OE=0 too); A, Data_in, UB and LB SHALL be latched; next state WR_COMMIT.
REQ-017 In IDLE, CE=0, OE=0 and WE=1 SHALL accept a read; A, UB and LB SHALL be latched; the latency counter SHALL load READ_LAT-1; next state RD_WAIT.
REQ-018 In IDLE with no strobe active, the block SHALL remain in IDLE and SHALL ignore A and Data_in.
REQ-019 WR_COMMIT SHALL write only the enabled byte lanes of the latched address, assert Ready, and go to DONE; the total is 1 cycle after acceptance.
REQ-020 RD_WAIT SHALL decrement the counter; at zero it SHALL load Data_out, assert Ready, and go to DONE; Ready therefore appears exactly READ_LAT cycles after acceptance.
REQ-021 A disabled read lane SHALL return 8'h00 in that byte of Data_out; UB=LB=1 SHALL still complete with Data_out=16'h0000.
REQ-022 Latched A[19:ADDR_BITS] nonzero: writes SHALL be dropped, reads SHALL return 16'h0000, and Err SHALL pulse with Ready.
REQ-023 In RD_WAIT, CE or OE going high SHALL abort the read: return to IDLE, no Ready, Data_out unchanged.
REQ-024 A write in WR_COMMIT SHALL NOT be abortable.
REQ-025 DONE SHALL hold until CE=1 or both OE=1 and WE=1, then go to IDLE; one strobe assertion yields exactly one access.
REQ-026 Data_out SHALL hold the last completed read value until the next read completes; writes SHALL NOT alter it.
REQ-027 A read of the address written by the immediately preceding write SHALL return the new data (no hazard window).

Reset
REQ-028 Reset high SHALL immediately force: state IDLE, Data_out=16'h0000, Ready=0, Err=0, counter=0, latched fields=0.
REQ-029 Reset SHALL NOT clear array contents; an access in flight at reset SHALL be discarded with no write performed.

Structure
REQ-030 Package slc_mem_pkg SHALL hold the FSM state enum, the ADDR_BITS/READ_LAT defaults and the lane-mask helper type.
REQ-031 Storage SHALL be a sub-module sram_array: single port, synchronous write with 2-bit byte enable, synchronous read.

Verification
REQ-032 Write A=0x00005 with Data_in=0xBEEF, UB=LB=0, then read A=0x00005 -> Ready 1 cycle after write acceptance; read Ready 2 cycles after acceptance with Data_out=0xBEEF.
REQ-033 After REQ-032, write 0x1234 with UB=1 and LB=0, then read with UB=LB=0 -> Data_out=0xBE34; read with LB=1 -> 0xBE00.
REQ-034 Read A=0x00400 (ADDR_BITS=10) -> Ready and Err pulse together, Data_out=0x0000; a write to A=0x00400 does not change address 0x000.
REQ-035 Start a read, then raise OE after 1 cycle -> no Ready, Data_out keeps its prior value, and the next read completes normally.
REQ-036 Hold CE=OE=0 for 10 cycles -> exactly one Ready pulse; assert Reset during RD_WAIT -> outputs zero at once, array contents retained.

Source files
------------

// File: rtl/slc_mem_pkg.sv
// Shared types and defaults for the SRAM responder slice: FSM states, parameter defaults,
// and the byte-lane mask helpers.
package slc_mem_pkg;

    localparam int unsigned DEFAULT_ADDR_BITS = 10;
    localparam int unsigned DEFAULT_READ_LAT  = 2;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_COMMIT, DONE} state_e;

    // Active-high lane enables: bit 1 = bits 15:8, bit 0 = bits 7:0.
    typedef logic [1:0] lane_mask_t;

    function automatic lane_mask_t lane_mask(input logic ub_n, input logic lb_n);
        return {~ub_n, ~lb_n};
    endfunction

    function automatic logic [15:0] mask_data(input lane_mask_t m, input logic [15:0] d);
        return {(m[1] ? d[15:8] : 8'h00), (m[0] ? d[7:0] : 8'h00)};
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Async-SRAM style strobe bus between an initiator (master) and the responder (slave).
interface sram_responder_if;

    logic        CE;
    logic        OE;
    logic        WE;
    logic        UB;
    logic        LB;
    logic [19:0] A;
    logic [15:0] Data_in;
    logic [15:0] Data_out;
    logic        Ready;
    logic        Err;

    modport master (
        output CE, OE, WE, UB, LB, A, Data_in,
        input  Data_out, Ready, Err
    );

    modport slave (
        input  CE, OE, WE, UB, LB, A, Data_in,
        output Data_out, Ready, Err
    );

endinterface

// File: rtl/sram_array.sv
// Single-port word storage: synchronous byte-enabled write, synchronous (registered) read.
module sram_array
    import slc_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 we,
    input  lane_mask_t           be,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    localparam int unsigned WORDS = 2 ** ADDR_BITS;

    logic [15:0] mem [WORDS];

    // No reset: contents must survive a responder reset.
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) mem[addr][7:0]  <= wdata[7:0];
            if (be[1]) mem[addr][15:8] <= wdata[15:8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sram_responder.sv
// Strobe-driven SRAM responder: latches an access on CE/OE/WE, completes it with a one-cycle
// Ready pulse (Err for unimplemented addresses) and holds until the strobes are released.
module sram_responder
    import slc_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int unsigned READ_LAT  = DEFAULT_READ_LAT
) (
    input  logic             Clk,
    input  logic             Reset,
    sram_responder_if.slave  bus
);

    state_e      state_q, state_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    lane_mask_t  lanes_q, lanes_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] dout_q, dout_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        in_range;

    assign in_range = ((addr_q >> ADDR_BITS) == 20'd0);

    // Array is addressed with the next latched address so a read's data is already
    // registered by the first RD_WAIT cycle, which makes READ_LAT=1 possible.
    sram_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk  (Clk),
        .addr (addr_d[ADDR_BITS-1:0]),
        .we   (mem_we),
        .be   (lanes_q),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lanes_d = lanes_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.CE && !bus.WE) begin
                    addr_d  = bus.A;
                    wdata_d = bus.Data_in;
                    lanes_d = lane_mask(bus.UB, bus.LB);
                    state_d = WR_COMMIT;
                end else if (!bus.CE && !bus.OE) begin
                    addr_d  = bus.A;
                    lanes_d = lane_mask(bus.UB, bus.LB);
                    cnt_d   = 3'(READ_LAT - 1);
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.CE || bus.OE) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    dout_d  = in_range ? mask_data(lanes_q, mem_rdata) : 16'h0000;
                    ready_d = 1'b1;
                    err_d   = !in_range;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR_COMMIT: begin
                mem_we  = in_range;
                ready_d = 1'b1;
                err_d   = !in_range;
                state_d = DONE;
            end
            DONE: begin
                if (bus.CE || (bus.OE && bus.WE)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            lanes_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lanes_q <= lanes_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign bus.Data_out = dout_q;
    assign bus.Ready    = ready_q;
    assign bus.Err      = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_sram_responder;

    localparam int unsigned ADDR_BITS = 10;
    localparam int unsigned READ_LAT  = 2;
    localparam int unsigned WORDS     = 2 ** ADDR_BITS;
    localparam int          MAX_WAIT  = 20;

    logic Clk;
    logic Reset;

    sram_responder_if bus_if ();

    sram_responder #(
        .ADDR_BITS(ADDR_BITS),
        .READ_LAT (READ_LAT)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [WORDS];
    logic [15:0] last_dout;
    logic [19:0] pool [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic release_bus();
        bus_if.CE = 1'b1;
        bus_if.OE = 1'b1;
        bus_if.WE = 1'b1;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus_if.Ready && lat < MAX_WAIT);
    endtask

    task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic ub,
                            input logic lb, input logic oe_too);
        int lat;
        logic oor;
        oor = (a >= 20'(WORDS));
        bus_if.CE = 1'b0; bus_if.WE = 1'b0; bus_if.OE = oe_too ? 1'b0 : 1'b1;
        bus_if.A = a; bus_if.Data_in = d; bus_if.UB = ub; bus_if.LB = lb;
        tick();
        wait_ready(lat);
        check("wr_latency", lat, 1);
        check("wr_err", bus_if.Err, oor);
        check("wr_dout_hold", bus_if.Data_out, last_dout);
        if (!oor) begin
            if (!ub) model_mem[a[ADDR_BITS-1:0]][15:8] = d[15:8];
            if (!lb) model_mem[a[ADDR_BITS-1:0]][7:0]  = d[7:0];
        end
        release_bus();
        tick();
    endtask

    task automatic do_read(input logic [19:0] a, input logic ub, input logic lb);
        int lat;
        logic oor;
        logic [15:0] w, exp;
        oor = (a >= 20'(WORDS));
        w   = oor ? 16'h0000 : model_mem[a[ADDR_BITS-1:0]];
        exp = {(ub ? 8'h00 : w[15:8]), (lb ? 8'h00 : w[7:0])};
        bus_if.CE = 1'b0; bus_if.OE = 1'b0; bus_if.WE = 1'b1;
        bus_if.A = a; bus_if.UB = ub; bus_if.LB = lb;
        bus_if.Data_in = 16'($urandom);
        tick();
        wait_ready(lat);
        check("rd_latency", lat, READ_LAT);
        check("rd_data", bus_if.Data_out, exp);
        check("rd_err", bus_if.Err, oor);
        last_dout = exp;
        release_bus();
        tick();
    endtask

    initial begin
        int pulses;
        logic [19:0] ra;
        pool = '{20'h00000, 20'h00005, 20'h00010, 20'h0007F, 20'h00100, 20'h002AA,
                 20'h003FE, 20'h003FF};
        last_dout = 16'h0000;
        release_bus();
        bus_if.UB = 1'b0; bus_if.LB = 1'b0; bus_if.A = '0; bus_if.Data_in = '0;
        Reset = 1'b1;
        repeat (2) tick();
        check("rst_dout", bus_if.Data_out, 16'h0000);
        check("rst_ready", bus_if.Ready, 1'b0);
        check("rst_err", bus_if.Err, 1'b0);
        Reset = 1'b0;
        tick();

        foreach (pool[i]) do_write(pool[i], 16'($urandom), 1'b0, 1'b0, 1'b0);

        // Full write then read-back of the same address
        do_write(20'h00005, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        do_read(20'h00005, 1'b0, 1'b0);
        check("beef_const", bus_if.Data_out, 16'hBEEF);

        // Lower-lane-only write, then full and lower-disabled reads
        do_write(20'h00005, 16'h1234, 1'b1, 1'b0, 1'b0);
        do_read(20'h00005, 1'b0, 1'b0);
        check("be34_const", bus_if.Data_out, 16'hBE34);
        do_read(20'h00005, 1'b0, 1'b1);
        check("be00_const", bus_if.Data_out, 16'hBE00);
        do_read(20'h00005, 1'b1, 1'b1);

        // Unimplemented address: no aliasing onto word 0
        do_read(20'h00400, 1'b0, 1'b0);
        do_write(20'h00400, 16'h5A5A, 1'b0, 1'b0, 1'b0);
        do_read(20'h00000, 1'b0, 1'b0);

        // Abort a read by raising OE after one cycle
        do_read(20'h00005, 1'b0, 1'b0);
        bus_if.CE = 1'b0; bus_if.OE = 1'b0; bus_if.WE = 1'b1; bus_if.A = 20'h00010;
        tick();
        bus_if.OE = 1'b1;
        pulses = 0;
        repeat (5) begin
            tick();
            if (bus_if.Ready) pulses++;
        end
        check("abort_no_ready", pulses, 0);
        check("abort_dout_hold", bus_if.Data_out, last_dout);
        release_bus();
        do_read(20'h00010, 1'b0, 1'b0);

        // Held strobe produces exactly one access
        bus_if.CE = 1'b0; bus_if.OE = 1'b0; bus_if.WE = 1'b1;
        bus_if.A = 20'h00005; bus_if.UB = 1'b0; bus_if.LB = 1'b0;
        pulses = 0;
        repeat (10) begin
            tick();
            if (bus_if.Ready) pulses++;
        end
        check("hold_one_pulse", pulses, 1);
        check("hold_data", bus_if.Data_out, model_mem[5]);
        last_dout = model_mem[5];
        release_bus();
        tick();

        // Reset in RD_WAIT clears outputs at once
        bus_if.CE = 1'b0; bus_if.OE = 1'b0; bus_if.WE = 1'b1; bus_if.A = 20'h00005;
        tick();
        Reset = 1'b1;
        #1;
        check("rst_rd_dout", bus_if.Data_out, 16'h0000);
        check("rst_rd_ready", bus_if.Ready, 1'b0);
        check("rst_rd_err", bus_if.Err, 1'b0);
        release_bus();
        tick();
        Reset = 1'b0;
        last_dout = 16'h0000;
        tick();
        do_read(20'h00005, 1'b0, 1'b0);

        // Reset in WR_COMMIT discards the write
        bus_if.CE = 1'b0; bus_if.WE = 1'b0; bus_if.OE = 1'b1;
        bus_if.A = 20'h002AA; bus_if.Data_in = 16'hDEAD; bus_if.UB = 1'b0; bus_if.LB = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
        release_bus();
        tick();
        Reset = 1'b0;
        last_dout = 16'h0000;
        tick();
        do_read(20'h002AA, 1'b0, 1'b0);

        // Randomized traffic with idle noise on A/Data_in
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) begin
                bus_if.A = 20'($urandom);
                bus_if.Data_in = 16'($urandom);
                bus_if.CE = 1'($urandom);
                tick();
                check("idle_ready", bus_if.Ready, 1'b0);
                release_bus();
            end
            if ($urandom_range(0, 7) == 0) ra = 20'($urandom) | 20'h00400;
            else ra = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1)
                do_write(ra, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            else
                do_read(ra, 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
